// File: rtl/periph_timer_pkg.sv
// Shared types and constants for the peripheral timer responder.
// Holds the store-type enum, register selectors, CTRL bits and FSM states.
package periph_timer_pkg;

   typedef enum logic [2:0] {
      NO_STORE,
      STORE_BYTE,
      STORE_HALF,
      STORE_WORD,
      STORE_DWORD
   } mem_store_type_t;

   // Register offsets within the 32-byte window; decoded on offset[4:3].
   localparam logic [4:0] OFF_CTRL    = 5'h00;
   localparam logic [4:0] OFF_COUNT   = 5'h08;
   localparam logic [4:0] OFF_COMPARE = 5'h10;
   localparam logic [4:0] OFF_STATUS  = 5'h18;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_COUNT   = 2'd1;
   localparam logic [1:0] REG_COMPARE = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_IRQ_EN      = 1;
   localparam int CTRL_AUTO_RELOAD = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } timer_state_t;

endpackage

// File: rtl/store_lane_merge.sv
// Merges a right-aligned store into a 64-bit word at the size-aligned lane.
// Ports: old_data/wdata (64b), store_type, addr_lo[2:0] in; merged (64b) out.
module store_lane_merge
   import periph_timer_pkg::*;
(
   input  logic [63:0]     old_data,
   input  logic [63:0]     wdata,
   input  mem_store_type_t store_type,
   input  logic [2:0]      addr_lo,
   output logic [63:0]     merged
);

   logic [63:0] size_mask;
   logic [63:0] lane_mask;
   logic [63:0] lane_data;
   logic [2:0]  lane;

   always_comb begin
      size_mask = '0;
      lane      = addr_lo;
      case (store_type)
         STORE_BYTE: size_mask = 64'h0000_0000_0000_00FF;
         STORE_HALF: begin
            size_mask = 64'h0000_0000_0000_FFFF;
            lane      = {addr_lo[2:1], 1'b0};
         end
         STORE_WORD: begin
            size_mask = 64'h0000_0000_FFFF_FFFF;
            lane      = {addr_lo[2], 2'b00};
         end
         STORE_DWORD: begin
            size_mask = '1;
            lane      = 3'd0;
         end
         default: size_mask = '0;
      endcase
      lane_mask = size_mask << {lane, 3'b000};
      lane_data = (wdata & size_mask) << {lane, 3'b000};
      merged    = (old_data & ~lane_mask) | lane_data;
   end

endmodule

// File: rtl/periph_timer_responder.sv
// Memory-mapped 64-bit timer answering core loads/stores with wait states.
// Ports: clock, reset (async low), d_* request/response bus, irq level out.
module periph_timer_responder
   import periph_timer_pkg::*;
#(
   parameter logic [63:0] BASE_ADDR   = 64'h2000_0000,
   parameter int          WAIT_CYCLES = 1,
   parameter int          PRESCALE    = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [63:0]     d_addr,
   input  logic [63:0]     d_wdata,
   output logic [63:0]     d_rdata,
   input  mem_store_type_t d_store_type,
   input  logic            d_valid,
   output logic            d_ready,
   output logic            irq
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [3:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   timer_state_t    state, state_nx;
   logic [63:0]     lat_addr, lat_wdata;
   mem_store_type_t lat_type;
   logic [3:0]      wait_cnt;
   logic [63:0]     rdata_q;

   logic [2:0]      ctrl;
   logic [63:0]     count, compare;
   logic            pending;
   logic [PW-1:0]   pre_cnt;
   logic            irq_q;

   logic [63:0]     regs [4];
   logic [63:0]     merged;

   // Offsets kept at dword granularity; the window base is dword aligned.
   logic [63:3]     req_addr, req_off, wr_off;
   logic            req_hit, wr_hit, wr_en;
   logic [1:0]      req_sel, wr_sel;
   logic            pre_wrap, match;

   always_comb begin
      regs[REG_CTRL]    = {61'd0, ctrl};
      regs[REG_COUNT]   = count;
      regs[REG_COMPARE] = compare;
      regs[REG_STATUS]  = {63'd0, pending};
   end

   // In IDLE the request is still on the bus (zero-wait path).
   assign req_addr = (state == IDLE) ? d_addr[63:3] : lat_addr[63:3];
   assign req_off  = req_addr - BASE_ADDR[63:3];
   assign req_hit  = ~|req_off[63:5];
   assign req_sel  = req_off[4:3];

   assign wr_off = lat_addr[63:3] - BASE_ADDR[63:3];
   assign wr_hit = ~|wr_off[63:5];
   assign wr_sel = wr_off[4:3];
   assign wr_en  = (state == RESP) && (lat_type != NO_STORE) && wr_hit;

   store_lane_merge u_merge (
      .old_data   (regs[wr_sel]),
      .wdata      (lat_wdata),
      .store_type (lat_type),
      .addr_lo    (lat_addr[2:0]),
      .merged     (merged)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (d_valid) state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
         WAIT: if (wait_cnt == 4'd0) state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      d_ready = (state == RESP);
      d_rdata = d_ready ? rdata_q : '0;
      irq     = irq_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_type  <= NO_STORE;
         wait_cnt  <= '0;
         rdata_q   <= '0;
      end else begin
         if (state == IDLE && d_valid) begin
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_type  <= d_store_type;
            wait_cnt  <= WAIT_INIT;
         end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (state != RESP && state_nx == RESP)
            rdata_q <= req_hit ? regs[req_sel] : '0;
      end
   end

   assign pre_wrap = ctrl[CTRL_EN] && (pre_cnt == PRE_LAST);
   assign match    = pre_wrap && (count == compare);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl    <= '0;
         count   <= '0;
         compare <= '1;
         pending <= 1'b0;
         pre_cnt <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (ctrl[CTRL_EN])
            pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
         // Software writes win over the timer's own count update.
         if (wr_en && wr_sel == REG_COUNT)
            count <= merged;
         else if (pre_wrap)
            count <= (match && ctrl[CTRL_AUTO_RELOAD]) ? '0 : count + 64'd1;
         if (wr_en && wr_sel == REG_COMPARE)
            compare <= merged;
         if (wr_en && wr_sel == REG_CTRL)
            ctrl <= merged[2:0];
         // A match on the same edge as a clear keeps the event visible.
         if (match)
            pending <= 1'b1;
         else if (wr_en && wr_sel == REG_STATUS && merged[0])
            pending <= 1'b0;
         irq_q <= pending & ctrl[CTRL_IRQ_EN];
      end
   end

endmodule

// File: tb/tb_periph_timer_responder.sv
// Self-checking bench for periph_timer_responder: two instances
// (1 wait/prescale 1 and 8 waits/prescale 3) driven by directed and random steps.
module tb_periph_timer_responder;
   import periph_timer_pkg::*;

   localparam logic [63:0] BASE = 64'h2000_0000;
   localparam int LAT_A = 2;
   localparam int LAT_B = 9;

   logic clk = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic            rst   [2];
   logic [63:0]     addr  [2];
   logic [63:0]     wdata [2];
   logic [63:0]     rdata [2];
   logic            valid [2];
   logic            ready [2];
   logic            irq   [2];
   mem_store_type_t st    [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   periph_timer_responder #(
      .BASE_ADDR(BASE), .WAIT_CYCLES(1), .PRESCALE(1)
   ) u_dut_a (
      .clock(clk), .reset(rst[0]), .d_addr(addr[0]), .d_wdata(wdata[0]),
      .d_rdata(rdata[0]), .d_store_type(st[0]), .d_valid(valid[0]),
      .d_ready(ready[0]), .irq(irq[0])
   );

   periph_timer_responder #(
      .BASE_ADDR(BASE), .WAIT_CYCLES(8), .PRESCALE(3)
   ) u_dut_b (
      .clock(clk), .reset(rst[1]), .d_addr(addr[1]), .d_wdata(wdata[1]),
      .d_rdata(rdata[1]), .d_store_type(st[1]), .d_valid(valid[1]),
      .d_ready(ready[1]), .irq(irq[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Byte-by-byte store reference: size-aligned lane, low bytes of data.
   function automatic logic [63:0] merge_ref(input logic [63:0] old,
         input logic [63:0] w, input mem_store_type_t t, input logic [2:0] a);
      logic [63:0] r;
      int n;
      int b0;
      r = old;
      case (t)
         STORE_BYTE:  n = 1;
         STORE_HALF:  n = 2;
         STORE_WORD:  n = 4;
         STORE_DWORD: n = 8;
         default:     n = 0;
      endcase
      if (n != 0) begin
         b0 = (int'(a) / n) * n;
         for (int i = 0; i < n; i++) r[8*(b0+i) +: 8] = w[8*i +: 8];
      end
      return r;
   endfunction

   // One request; returns data and the cycle count at the d_ready pulse.
   task automatic xfer(input int s, input logic [63:0] a, input logic [63:0] w,
         input mem_store_type_t t, input string tag,
         output logic [63:0] rd, output int rc);
      int n;
      bit got;
      bit quiet;
      addr[s] = a; wdata[s] = w; st[s] = t; valid[s] = 1'b1;
      n = 0; got = 0; quiet = 1;
      while (!got && n < 64) begin
         @(negedge clk);
         n++;
         if (ready[s]) got = 1;
         else if (rdata[s] !== 64'd0) quiet = 0;
      end
      rd = rdata[s];
      rc = cyc;
      valid[s] = 1'b0;
      st[s] = NO_STORE;
      chk({tag, "_lat"}, 64'(n), 64'((s == 0) ? LAT_A : LAT_B));
      chk({tag, "_quiet"}, 64'(quiet), 64'd1);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(ready[s]), 64'd0);
   endtask

   task automatic ld(input int s, input logic [63:0] a,
                     input logic [63:0] exp, input string tag);
      logic [63:0] rd;
      int rc;
      xfer(s, a, 64'd0, NO_STORE, tag, rd, rc);
      chk(tag, rd, exp);
   endtask

   initial begin : main
      logic [63:0] rd, m_cnt, m_cmp, a, w, exp;
      mem_store_type_t t;
      int rc, ew, ef, c, k, n1, n2, pulses;

      for (int s = 0; s < 2; s++) begin
         rst[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
         valid[s] = 1'b0; st[s] = NO_STORE;
      end
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("rst_ready", 64'(ready[s]), 64'd0);
         chk("rst_rdata", rdata[s], 64'd0);
         chk("rst_irq", 64'(irq[s]), 64'd0);
      end
      rst[0] = 1'b1; rst[1] = 1'b1;
      @(negedge clk);

      ld(0, BASE + 64'h10, '1, "cmp_reset");
      ld(0, BASE + 64'h00, 64'd0, "ctrl_reset");
      ld(0, BASE + 64'h08, 64'd0, "count_reset");
      ld(0, BASE + 64'h18, 64'd0, "status_reset");

      xfer(0, BASE, 64'hFFFF_FFFF_FFFF_FFFE, STORE_DWORD, "ctrl_wr", rd, rc);
      ld(0, BASE, 64'd6, "ctrl_mask");

      xfer(0, BASE + 64'h10, 64'd0, STORE_DWORD, "cmp_clr", rd, rc);
      xfer(0, BASE + 64'h12, 64'hAB, STORE_BYTE, "cmp_byte", rd, rc);
      ld(0, BASE + 64'h10, 64'h0000_0000_00AB_0000, "cmp_byte");
      xfer(0, BASE + 64'h13, 64'h1234, STORE_HALF, "cmp_half", rd, rc);
      ld(0, BASE + 64'h10, 64'h0000_0000_1234_0000, "cmp_half");

      xfer(0, BASE + 64'h20, '1, STORE_DWORD, "oor_wr", rd, rc);
      ld(0, BASE + 64'h08, 64'd0, "oor_wr_nofx");
      ld(0, BASE - 64'h8, 64'd0, "oor_below");

      m_cnt = 64'd0;
      m_cmp = 64'h0000_0000_1234_0000;
      for (int i = 0; i < 40; i++) begin
         k = int'($urandom_range(0, 3));
         t = mem_store_type_t'($urandom_range(0, 4));
         w = {$urandom, $urandom};
         case (k)
            0: a = BASE + 64'h08 + 64'($urandom_range(0, 7));
            1: a = BASE + 64'h10 + 64'($urandom_range(0, 7));
            2: a = BASE + 64'h18 + 64'($urandom_range(0, 7));
            default:
               if ($urandom_range(0, 1) == 1)
                  a = BASE + 64'h20 + 64'($urandom_range(0, 255));
               else
                  a = BASE - 64'($urandom_range(1, 64));
         endcase
         case (k)
            0: exp = m_cnt;
            1: exp = m_cmp;
            default: exp = 64'd0;
         endcase
         xfer(0, a, w, t, "rnd", rd, rc);
         if (t == NO_STORE) chk("rnd_load", rd, exp);
         else if (k == 0) m_cnt = merge_ref(m_cnt, w, t, a[2:0]);
         else if (k == 1) m_cmp = merge_ref(m_cmp, w, t, a[2:0]);
      end
      ld(0, BASE + 64'h08, m_cnt, "rnd_count");
      ld(0, BASE + 64'h10, m_cmp, "rnd_cmp");

      // Back-to-back: valid held, address changed right after the pulse.
      addr[0] = BASE + 64'h10; st[0] = NO_STORE; valid[0] = 1'b1;
      n1 = 0;
      while (!ready[0] && n1 < 32) begin @(negedge clk); n1++; end
      chk("b2b_lat1", 64'(n1), 64'(LAT_A));
      chk("b2b_data1", rdata[0], m_cmp);
      addr[0] = BASE + 64'h40;
      n2 = 0;
      do begin @(negedge clk); n2++; end while (!ready[0] && n2 < 32);
      chk("b2b_lat2", 64'(n2), 64'd3);
      chk("b2b_data2", rdata[0], 64'd0);
      valid[0] = 1'b0;
      @(negedge clk);
      chk("b2b_end", 64'(ready[0]), 64'd0);

      // Timer with auto-reload: count runs 0..5 with period 6 edges.
      xfer(0, BASE + 64'h10, 64'd5, STORE_DWORD, "t_cmp", rd, rc);
      xfer(0, BASE + 64'h08, 64'd0, STORE_DWORD, "t_cnt", rd, rc);
      xfer(0, BASE, 64'd7, STORE_DWORD, "t_en", rd, rc);
      ew = rc + 1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         chk("irq_rise", 64'(irq[0]), 64'(i >= 7));
      end
      repeat ($urandom_range(0, 7)) @(negedge clk);
      c = cyc;
      ld(0, BASE + 64'h08, 64'((c + 1 - ew) % 6), "t_count");

      while (((cyc + 3 - ew) % 6) != 0) @(negedge clk);
      xfer(0, BASE + 64'h18, 64'd1, STORE_DWORD, "w1c_m", rd, rc);
      ld(0, BASE + 64'h18, 64'd1, "w1c_vs_match");
      while (((cyc + 3 - ew) % 6) != 1) @(negedge clk);
      xfer(0, BASE + 64'h18, 64'd1, STORE_DWORD, "w1c_n", rd, rc);
      ld(0, BASE + 64'h18, 64'd0, "w1c_clear");

      xfer(0, BASE, 64'd2, STORE_DWORD, "t_dis", rd, rc);
      chk("irq_set", 64'(irq[0]), 64'd1);
      xfer(0, BASE + 64'h18, 64'd1, STORE_BYTE, "w1c_off", rd, rc);
      chk("irq_lag", 64'(irq[0]), 64'd1);
      @(negedge clk);
      chk("irq_drop", 64'(irq[0]), 64'd0);
      ld(0, BASE + 64'h18, 64'd0, "status_off");

      // Prescaled instance: count advances once per three edges.
      xfer(1, BASE + 64'h10, 64'h55, STORE_DWORD, "b_cmp", rd, rc);
      xfer(1, BASE + 64'h08, 64'h77, STORE_DWORD, "b_cnt", rd, rc);
      xfer(1, BASE, 64'd1, STORE_DWORD, "b_en", rd, rc);
      ew = rc + 1;
      repeat ($urandom_range(2, 20)) @(negedge clk);
      c = cyc;
      ld(1, BASE + 64'h08, 64'h77 + 64'((c + 8 - ew) / 3), "b_run");
      xfer(1, BASE, 64'd0, STORE_DWORD, "b_dis", rd, rc);
      ef = rc + 1;
      repeat ($urandom_range(2, 10)) @(negedge clk);
      ld(1, BASE + 64'h08, 64'h77 + 64'((ef - ew) / 3), "b_frozen");

      // Reset while the request sits in WAIT.
      addr[1] = BASE + 64'h10; st[1] = NO_STORE; valid[1] = 1'b1;
      pulses = 0;
      repeat (4) begin @(negedge clk); if (ready[1]) pulses++; end
      rst[1] = 1'b0; valid[1] = 1'b0;
      repeat (4) begin @(negedge clk); if (ready[1]) pulses++; end
      rst[1] = 1'b1;
      repeat (15) begin @(negedge clk); if (ready[1]) pulses++; end
      chk("rst_mid_pulses", 64'(pulses), 64'd0);
      chk("rst_mid_rdata", rdata[1], 64'd0);
      ld(1, BASE + 64'h08, 64'd0, "b_rst_count");
      ld(1, BASE + 64'h10, '1, "b_rst_cmp");
      ld(1, BASE + 64'h00, 64'd0, "b_rst_ctrl");
      ld(1, BASE + 64'h18, 64'd0, "b_rst_status");
      chk("b_rst_irq", 64'(irq[1]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/periph_timer_responder.md
Name: periph_timer_responder

Overview:
- Responder end of the core's peripheral data interface (d_addr/d_wdata/d_rdata/d_store_type/d_valid/d_ready).
- Memory-mapped 64-bit timer placed at PERIPHERAL_BASE.
- Answers core loads and stores with a fixed wait-state handshake.
- Drives one interrupt line into the core's interrupt_sources vector.

Parameters:
- BASE_ADDR, 64'h2000_0000, base of the 32-byte register window.
- WAIT_CYCLES, 1, cycles between accept and d_ready; range 0..15.
- PRESCALE, 1, clock cycles per COUNT increment; must be >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- d_addr  input  64  byte address from the core.
- d_wdata  input  64  store data, right-aligned in the low bytes.
- d_rdata  output  64  load data; valid only while d_ready=1.
- d_store_type  input  mem_store_type_t  NO_STORE means a load; other values are BYTE/HALF/WORD/DWORD stores.
- d_valid  input  1  request valid; held by the core until d_ready.
- d_ready  output  1  one-cycle completion pulse.
- irq  output  1  timer interrupt, level.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, d_ready=0, d_rdata=0, irq=0, CTRL=0, COUNT=0, COMPARE=all ones, STATUS=0, prescaler counter=0.
- Register map, offset = d_addr - BASE_ADDR, decoded on offset[4:3]:
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
  - 0x08 COUNT.
  - 0x10 COMPARE.
  - 0x18 STATUS: bit0 PENDING; write-1-to-clear.
- Addresses outside [BASE_ADDR, BASE_ADDR+32): load returns 0, store is ignored, handshake still completes.
- FSM:
  - IDLE: if d_valid=1, latch addr, wdata and store_type. Go to WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: count down the latched wait value; at 0 go to RESP.
  - RESP: d_ready=1 for exactly this cycle; d_rdata=registered read data; then go to IDLE.
  - d_ready is registered (Moore), so minimum latency is accept+1 cycle and total latency is WAIT_CYCLES+1 cycles after d_valid is first seen.
- A d_valid high in the IDLE cycle right after RESP is a new request (back-to-back). There are no duplicate accepts.
- Read data is sampled from the registers at the WAIT→RESP (or IDLE→RESP) transition. It is the full 64-bit register with no lane shifting; the core extracts the bytes it needs. d_rdata is 0 when d_ready=0.
- Store merge, applied in the RESP cycle:
  - Lane = latched addr[2:0] aligned down to the access size.
  - BYTE writes wdata[7:0] into that lane; HALF writes wdata[15:0]; WORD writes wdata[31:0]; DWORD writes all 64 bits.
  - Bytes outside the written lane keep their old values.
  - For STATUS, merged bit0=1 clears PENDING.
- Timer:
  - While EN=1, the prescaler counts 0..PRESCALE-1. On wrap, COUNT increments modulo 2^64.
  - EN=0 freezes both COUNT and the prescaler.
- Match: when EN=1 and COUNT==COMPARE on a prescaler wrap edge:
  - PENDING is set.
  - If AUTO_RELOAD=1, COUNT loads 0 instead of incrementing.
- irq = PENDING & IRQ_EN, registered, updating one cycle after PENDING.
- Simultaneous events:
  - Software write to COUNT beats an increment or reload in the same cycle.
  - A match-set beats a W1C clear in the same cycle, so PENDING stays 1.
  - A write to CTRL takes effect starting the next cycle.
- Reset asserted mid-transaction: return to IDLE immediately, drop the request with no d_ready pulse. The core is reset by the same signal.

Decomposition:
- Package periph_timer_pkg holds:
  - Register offset localparams.
  - CTRL bit index constants.
  - The FSM state enum: IDLE, WAIT, RESP.
- mem_store_type_t is reused from the existing structures package.
- Sub-module store_lane_merge: combinational (old 64b, wdata, store_type, addr[2:0]) → merged 64b. It is shared with future peripherals.

Test Plan:
- Reset, then load at 0x2000_0010 with WAIT_CYCLES=1 → d_ready pulses exactly at cycle 2 after d_valid with d_rdata=0xFFFF_FFFF_FFFF_FFFF; d_ready=0 in every other cycle.
- DWORD store 0x5 to COMPARE, DWORD store 0x7 to CTRL (EN|IRQ_EN|AUTO_RELOAD), PRESCALE=1 → PENDING set when COUNT=5, COUNT returns to 0, irq rises one cycle later.
- BYTE store 0xAB to 0x2000_0012 while COMPARE=0 → COMPARE reads 0x0000_0000_00AB_0000; HALF store 0x1234 at 0x2000_0013 writes lane bytes [3:2] → 0x0000_0000_1234_0000.
- Store 0x1 to STATUS in the same cycle a match occurs → PENDING remains 1; a repeat W1C with no match → PENDING=0 and irq drops one cycle later.
- Back-to-back requests: hold d_valid across two requests, changing d_addr immediately after the d_ready pulse → two separate d_ready pulses, each with the correct data; load at 0x2000_0040 → d_rdata=0.
- Assert reset during WAIT with WAIT_CYCLES=8 → no d_ready pulse, all registers return to reset values, a new request after reset completes normally.
